// File: rtl/ctrl_pipe_decoder.sv
// Registered control decoder: decodes an opcode into an 8-bit control word and
// carries it down an NSTAGE-deep valid-tagged pipe with stall, flush and retire count.

module ctrl_pipe_stage #(
  parameter bit CLEAR = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush_i,
  input  logic [7:0] word_i,
  input  logic       vld_i,
  output logic [7:0] word_o,
  output logic       vld_o
);
  logic [7:0] word_q;
  logic       vld_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (CLEAR && flush_i) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_i;
      vld_q  <= vld_i;
    end
  end

  assign word_o = word_q;
  assign vld_o  = vld_q;
endmodule

module ctrl_pipe_decoder #(
  parameter int OPW         = 5,
  parameter int NSTAGE      = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNTW        = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [OPW-1:0]        opcode,
  input  logic                  isR,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [8*NSTAGE-1:0]   ctrl_flat,
  output logic [NSTAGE-1:0]     valid_flat,
  output logic                  illegal,
  output logic [CNTW-1:0]       retired
);
  typedef struct packed {
    logic br, jp, aluinb, aluop, dmwe, rwe, rdst, rwd;
  } ctrl_t;

  logic [4:0]               op5;
  logic                     hi_bad;
  ctrl_t                    dec;
  logic                     dec_legal;
  logic                     load;
  logic [NSTAGE-1:0][7:0]   word_d, word_q;
  logic [NSTAGE-1:0]        vld_d, vld_q;
  logic                     ill_q;
  logic [CNTW-1:0]          ret_q;

  assign op5 = opcode[4:0];

  if (OPW > 5) begin : g_hi
    assign hi_bad = |opcode[OPW-1:5];
  end else begin : g_nohi
    assign hi_bad = 1'b0;
  end

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    if (isR) begin
      dec_legal = (op5 == 5'd0);
      dec.rwe   = dec_legal;
      dec.rdst  = dec_legal;
    end else begin
      unique case (op5)
        5'b00000: ;
        5'b00101: begin dec.aluinb = 1'b1; dec.rwe  = 1'b1; end
        5'b00111: begin dec.aluinb = 1'b1; dec.dmwe = 1'b1; end
        5'b01000: begin dec.aluinb = 1'b1; dec.rwe  = 1'b1; dec.rwd = 1'b1; end
        5'b00001: dec.jp = 1'b1;
        5'b00011: begin dec.jp = 1'b1; dec.rwe = 1'b1; end
        5'b00100: dec.jp = 1'b1;
        5'b00010, 5'b00110: begin dec.br = 1'b1; dec.aluop = 1'b1; end
        default:  dec_legal = 1'b0;
      endcase
    end
    // An illegal opcode must never leak a partial word into the pipe
    if (hi_bad || !dec_legal) begin
      dec       = '0;
      dec_legal = 1'b0;
    end
  end

  assign load = in_valid && !stall && !flush;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    if (k == 0) begin : g_head
      assign word_d[0] = load ? dec : '0;
      assign vld_d[0]  = load && dec_legal;
    end else begin : g_tail
      assign word_d[k] = word_q[k-1];
      assign vld_d[k]  = vld_q[k-1];
    end
    ctrl_pipe_stage #(.CLEAR(k < FLUSH_DEPTH)) u_stg (
      .clock   (clock),
      .reset_n (reset_n),
      .flush_i (flush),
      .word_i  (word_d[k]),
      .vld_i   (vld_d[k]),
      .word_o  (word_q[k]),
      .vld_o   (vld_q[k])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ill_q <= 1'b0;
      ret_q <= '0;
    end else begin
      if (load && !dec_legal) ill_q <= 1'b1;
      else if (err_clr)       ill_q <= 1'b0;
      if (vld_q[NSTAGE-1])    ret_q <= ret_q + 1'b1;
    end
  end

  assign ctrl_flat  = word_q;
  assign valid_flat = vld_q;
  assign illegal    = ill_q;
  assign retired    = ret_q;
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Bench for ctrl_pipe_decoder: directed scenarios with literal expectations plus
// a long random run, all compared every cycle against a table-driven pipe model.

module tb_ctrl_pipe_decoder;
  localparam int OPW = 6, NS = 3, FD = 2, CW = 4;

  logic clock = 1'b0, reset_n = 1'b1;
  logic in_valid = 1'b0, isR = 1'b0, stall = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [OPW-1:0]  opcode = '0;
  logic [8*NS-1:0] ctrl_flat;
  logic [NS-1:0]   valid_flat;
  logic            illegal;
  logic [CW-1:0]   retired;

  int checks = 0, errors = 0;
  int tbl[32];
  int mw[NS];
  bit mv[NS];
  bit mill;
  int mret;
  int legal_ops[9] = '{0, 5, 7, 8, 1, 3, 4, 2, 6};
  int sweep_op[9]  = '{0, 5, 7, 8, 1, 3, 4, 2, 6};
  int sweep_exp[9] = '{'h06, 'h24, 'h28, 'h25, 'h40, 'h44, 'h40, 'h90, 'h90};
  int r0;

  ctrl_pipe_decoder #(.OPW(OPW), .NSTAGE(NS), .FLUSH_DEPTH(FD), .CNTW(CW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .opcode(opcode),
    .isR(isR), .stall(stall), .flush(flush), .err_clr(err_clr),
    .ctrl_flat(ctrl_flat), .valid_flat(valid_flat), .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // -1 marks an illegal encoding
  function automatic int lookup(input logic [OPW-1:0] op, input logic r);
    if (op > 31) return -1;
    if (r) return (op == 0) ? 'h06 : -1;
    return tbl[op[4:0]];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin mw[k] = 0; mv[k] = 1'b0; end
    mill = 1'b0;
    mret = 0;
  endtask

  task automatic model_step();
    int w;
    bit ld;
    if (!reset_n) begin model_reset(); return; end
    if (mv[NS-1]) mret = (mret + 1) % (1 << CW);
    for (int k = NS - 1; k > 0; k--) begin mw[k] = mw[k-1]; mv[k] = mv[k-1]; end
    ld = in_valid && !stall && !flush;
    w  = lookup(opcode, isR);
    mw[0] = (ld && w >= 0) ? w : 0;
    mv[0] = ld && (w >= 0);
    if (flush) for (int k = 0; k < FD; k++) begin mw[k] = 0; mv[k] = 1'b0; end
    if (ld && w < 0) mill = 1'b1;
    else if (err_clr) mill = 1'b0;
  endtask

  task automatic compare();
    logic [8*NS-1:0] ec;
    logic [NS-1:0]   ev;
    for (int k = 0; k < NS; k++) begin ec[8*k +: 8] = 8'(mw[k]); ev[k] = mv[k]; end
    chk("ctrl_flat", 32'(ctrl_flat), 32'(ec));
    chk("valid_flat", 32'(valid_flat), 32'(ev));
    chk("illegal", 32'(illegal), 32'(mill));
    chk("retired", 32'(retired), 32'(mret));
  endtask

  task automatic cyc(input bit v, input logic [OPW-1:0] op, input bit r,
                     input bit s, input bit f, input bit e);
    in_valid = v; opcode = op; isR = r; stall = s; flush = f; err_clr = e;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = -1;
    tbl[0] = 'h00; tbl[5] = 'h24; tbl[7] = 'h28; tbl[8] = 'h25; tbl[1] = 'h40;
    tbl[3] = 'h44; tbl[4] = 'h40; tbl[2] = 'h90; tbl[6] = 'h90;
    model_reset();

    // reset held with random inputs
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); opcode = OPW'($urandom); isR = 1'($urandom);
      stall = 1'($urandom); flush = 1'($urandom); err_clr = 1'($urandom);
      @(negedge clock);
      chk("rst_ctrl", 32'(ctrl_flat), 0);
      chk("rst_valid", 32'(valid_flat), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_retired", 32'(retired), 0);
    end
    reset_n = 1'b1;

    // lw walks the pipe
    cyc(1, 6'd8, 0, 0, 0, 0);
    chk("lw_s0", 32'(ctrl_flat[7:0]), 'h25);   chk("lw_v0", 32'(valid_flat), 'b001);
    idle(1);
    chk("lw_s1", 32'(ctrl_flat[15:8]), 'h25);  chk("lw_v1", 32'(valid_flat), 'b010);
    idle(1);
    chk("lw_s2", 32'(ctrl_flat[23:16]), 'h25); chk("lw_v2", 32'(valid_flat), 'b100);
    idle(1);
    chk("lw_retired", 32'(retired), 1);

    // full decode sweep
    for (int i = 0; i < 9; i++) begin
      cyc(1, OPW'(sweep_op[i]), i == 0, 0, 0, 0);
      chk("sweep", 32'(ctrl_flat[7:0]), 32'(sweep_exp[i]));
    end
    idle(4);

    // stall bubbles
    r0 = int'(retired);
    cyc(1, 6'd5, 0, 0, 0, 0); chk("stall_a", 32'(ctrl_flat[7:0]), 'h24);
    cyc(1, 6'd7, 0, 1, 0, 0); chk("stall_b", 32'(ctrl_flat[7:0]), 'h00);
    cyc(1, 6'd7, 0, 1, 0, 0); chk("stall_c", 32'(ctrl_flat[7:0]), 'h00);
    cyc(1, 6'd7, 0, 0, 0, 0); chk("stall_d", 32'(ctrl_flat[7:0]), 'h28);
    idle(4);
    chk("stall_retired", 32'((int'(retired) - r0) & 15), 2);

    // flush has priority over stall
    cyc(1, 6'd5, 0, 0, 0, 0);
    cyc(1, 6'd7, 0, 0, 0, 0);
    cyc(1, 6'd8, 0, 0, 0, 0);
    cyc(1, 6'd5, 0, 1, 1, 0);
    chk("flush_ctrl", 32'(ctrl_flat), 'h280000);
    chk("flush_valid", 32'(valid_flat), 'b100);
    idle(3);

    // sticky illegal flag
    cyc(0, '0, 0, 0, 0, 1);
    cyc(1, 6'h1F, 0, 0, 0, 0);
    chk("ill_s0", 32'(ctrl_flat[7:0]), 0); chk("ill_v0", 32'(valid_flat[0]), 0);
    chk("ill_set", 32'(illegal), 1);
    idle(2);
    chk("ill_sticky", 32'(illegal), 1);
    cyc(1, 6'h1F, 0, 0, 0, 1); chk("ill_set_over_clr", 32'(illegal), 1);
    cyc(0, '0, 0, 0, 0, 1);    chk("ill_clr", 32'(illegal), 0);
    cyc(1, 6'b100101, 0, 0, 0, 0); chk("ill_hibits", 32'(illegal), 1);
    cyc(0, '0, 0, 0, 0, 1);
    cyc(1, 6'd5, 1, 0, 0, 0);  chk("ill_isr", 32'(illegal), 1);

    // counter wrap
    reset_n = 1'b0; idle(1); reset_n = 1'b1;
    for (int i = 0; i < 17; i++) cyc(1, 6'd5, 0, 0, 0, 0);
    idle(4);
    chk("wrap_retired", 32'(retired), 1);

    // async reset between edges
    cyc(1, 6'd5, 0, 0, 0, 0);
    cyc(1, 6'h1F, 0, 0, 0, 0);
    cyc(1, 6'd8, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl_flat), 0);   chk("arst_valid", 32'(valid_flat), 0);
    chk("arst_illegal", 32'(illegal), 0);  chk("arst_retired", 32'(retired), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [OPW-1:0] op;
      reset_n = ($urandom_range(0, 199) != 0);
      op = ($urandom_range(0, 9) < 8) ? OPW'(legal_ops[$urandom_range(0, 8)]) : OPW'($urandom);
      cyc($urandom_range(0, 9) < 8, op, $urandom_range(0, 7) == 0,
          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe_decoder.md
Name: ctrl_pipe_decoder

Overview:
- Parametrised, registered successor to the single-cycle control decoder.
- Decodes a fetched opcode into the 8-bit control word {BR, JP, ALUinB, ALUop, DMwe, Rwe, Rdst, Rwd}, bit 7 down to bit 0.
- Carries the word down an NSTAGE-deep control pipeline (EX, MEM, WB, ...), with a valid bit per stage, stall bubble insertion, partial flush, illegal-opcode detection and a retired-instruction counter.
- Sits between instruction fetch/decode and the datapath stage registers.

Parameters:
- OPW, 5: opcode width. Must be ≥5; any nonzero bit above bit 4 makes the opcode illegal.
- NSTAGE, 3: number of control pipeline stages. Must be ≥2. Stage 0 is EX; stage NSTAGE-1 is the last.
- FLUSH_DEPTH, 1: number of leading stages (0..FLUSH_DEPTH-1) cleared by flush. Range 1..NSTAGE.
- CNTW, 16: width of the retired-instruction counter.

Ports:
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: opcode/isR are valid this cycle.
- opcode, in, OPW: instruction opcode.
- isR, in, 1: R-type indicator from fetch.
- stall, in, 1: hazard stall; inserts a bubble into stage 0.
- flush, in, 1: branch/jump redirect; clears stages 0..FLUSH_DEPTH-1.
- err_clr, in, 1: clears the sticky illegal flag.
- ctrl_flat, out, 8*NSTAGE: control word per stage; stage k occupies bits [8k+7:8k].
- valid_flat, out, NSTAGE: valid bit per stage.
- illegal, out, 1: sticky illegal-opcode flag.
- retired, out, CNTW: count of valid words leaving the last stage.

Behaviour:
- Reset:
  - Every output is 0 and every stage holds control word 0 with valid 0. No clock is needed.
  - Deasserting reset_n mid-operation discards all in-flight words.
- Decode (combinational, opcode[4:0]; upper bits must be 0):
  - isR=1 with opcode 00000: Rwe, Rdst.
  - 00101 addi: ALUinB, Rwe.
  - 00111 sw: ALUinB, DMwe.
  - 01000 lw: ALUinB, Rwe, Rwd.
  - 00001 j: JP.
  - 00011 jal: JP, Rwe.
  - 00100 jr: JP.
  - 00010 bne: BR, ALUop.
  - 00110 blt: BR, ALUop.
  - isR=0 with opcode 00000: legal nop, word 0.
  - Anything else is illegal: word forced to 0, including isR=1 with a nonzero opcode.
- Stage 0 load on each edge:
  - If in_valid=1, stall=0 and flush=0: load the decoded word and set valid = legal.
  - Otherwise: load word 0 with valid 0.
- Stage advance:
  - Stage k (k≥1) takes stage k-1 every cycle. Stall does not freeze downstream stages.
  - Latency: opcode to stage 0 is 1 cycle; to stage k is k+1 cycles.
- Flush:
  - Stages 0..FLUSH_DEPTH-1 load word 0 with valid 0 on that edge, overriding the normal shift.
  - Stages at index ≥FLUSH_DEPTH shift normally.
- Simultaneous events: flush has priority over stall. Stall with in_valid=0 has no extra effect.
- illegal flag:
  - Set on the edge where in_valid=1, stall=0, flush=0 and the opcode is illegal.
  - Set has priority over err_clr in the same cycle.
  - Cleared only by err_clr or reset.
- retired counter:
  - Increments on each edge where valid of stage NSTAGE-1 is 1 (the word leaving the last stage).
  - Wraps modulo 2^CNTW with no saturation and no flag.
- Invalid stages always present control word 0, so DMwe and Rwe are never asserted for a bubble.

Test Plan:
- Reset/basic: hold reset_n=0 with random inputs → all outputs 0. Release, then present lw (01000) for one cycle → ctrl_flat[7:0]=0x25 one edge later; stage 1 shows 0x25 next cycle, stage 2 the cycle after; valid_flat 001→010→100; retired=1 one edge after it leaves stage 2.
- Full decode sweep: R, addi, sw, lw, j, jal, jr, bne, blt back-to-back → stage 0 words 0x06, 0x24, 0x28, 0x25, 0x40, 0x44, 0x40, 0x90, 0x90 on successive cycles.
- Stall: addi, then stall=1 for 2 cycles, then sw → stage 0 shows 0x24, 0x00, 0x00, 0x28; downstream stages keep advancing; after the pipe drains, retired=2.
- Flush priority: NSTAGE=3, FLUSH_DEPTH=2, pipe full of valid words, then assert flush and stall together → stages 0 and 1 become 0 with valid 0; stage 2 takes the old stage 1 word.
- Illegal/sticky: opcode 11111 with in_valid=1 → stage 0 word 0, valid 0, illegal=1. It stays 1 until err_clr. Illegal opcode plus err_clr in the same cycle → illegal stays 1. OPW=6 with opcode 100101 → illegal.
- Counter wrap/async reset: CNTW=4, stream 17 valid addi → retired=1. Pulse reset_n low between clock edges mid-stream → all outputs 0 immediately.
